// File: rtl/dm_main_memory_responder.sv
// rtl/dm_main_memory_responder.sv - line-wide main-memory responder with programmable access latency
// Optional MEM_ZERO_INIT_EN: zero every storage line after reset before accepting requests.
module dm_main_memory_responder #(
   parameter int LATENCY       = 4,
   parameter int LINE_BITS     = 128,
   parameter int NUM_MEM_LINES = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_req,
   input  logic                 mem_we,
   input  logic [15:0]          mem_addr,
   input  logic [LINE_BITS-1:0] mem_wdata,
   output logic                 mem_ready,
   output logic                 mem_resp_valid,
   output logic [LINE_BITS-1:0] mem_rdata
);

   localparam int ADDR_LENGTH   = 16;
   localparam int OFFSET_LENGTH = 4;
   localparam int IDX_BITS      = ADDR_LENGTH - OFFSET_LENGTH;
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [7:0]            cnt;
   logic                  lat_we;
   logic [IDX_BITS-1:0]   lat_idx;
   logic [LINE_BITS-1:0]  lat_wdata;
   logic [LINE_BITS-1:0]  storage [NUM_MEM_LINES];
   logic                  access;
   logic                  unused_offset;
`ifdef MEM_ZERO_INIT_EN
   logic [IDX_BITS-1:0]   clr_ptr;
`endif

   // Access happens on the last WAIT edge; reset forces IDLE/CLEAR so an aborted write never commits.
   assign access        = (state == WAIT) && (cnt == 8'd0);
   assign unused_offset = ^mem_addr[OFFSET_LENGTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
`ifdef MEM_ZERO_INIT_EN
         state <= CLEAR;
`else
         state <= IDLE;
`endif
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mem_req) state_nxt = WAIT;
         WAIT:    if (cnt == 8'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
`ifdef MEM_ZERO_INIT_EN
         CLEAR:   if (clr_ptr == {IDX_BITS{1'b1}}) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_ready      = (state == IDLE);
      mem_resp_valid = (state == RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= 8'd0;
         lat_we    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         mem_rdata <= '0;
`ifdef MEM_ZERO_INIT_EN
         clr_ptr   <= '0;
`endif
      end else begin
         if (state == IDLE && mem_req) begin
            lat_we    <= mem_we;
            lat_idx   <= mem_addr[ADDR_LENGTH-1:OFFSET_LENGTH];
            lat_wdata <= mem_wdata;
            cnt       <= CNT_LOAD;
         end else if (state == WAIT && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
         if (access) begin
            mem_rdata <= lat_we ? '0 : storage[lat_idx];
         end
`ifdef MEM_ZERO_INIT_EN
         if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
         end
`endif
      end
   end

   // Storage has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
`ifdef MEM_ZERO_INIT_EN
      if (state == CLEAR) storage[clr_ptr] <= '0;
      else
`endif
      if (access && lat_we) storage[lat_idx] <= lat_wdata;
   end

endmodule

// File: tb/tb_dm_main_memory_responder.sv
// tb/tb_dm_main_memory_responder.sv - randomized bench for two responders (LATENCY 4 and 1) against a timestamp model
module tb_dm_main_memory_responder;

   localparam logic [127:0] P1  = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
   localparam logic [127:0] P3  = 128'h33333333_44444444_55555555_66666666;
   localparam logic [127:0] P4  = 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE;
   localparam logic [127:0] P5A = 128'hA5A5A5A5_00000000_FFFFFFFF_5A5A5A5A;
   localparam logic [127:0] P5B = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
`ifdef MEM_ZERO_INIT_EN
   localparam int   CLR_CYC   = 4096;
   localparam logic RST_READY = 1'b0;
`else
   localparam int   CLR_CYC   = 0;
   localparam logic RST_READY = 1'b1;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req   [2];
   logic         we    [2];
   logic [15:0]  addr  [2];
   logic [127:0] wdata [2];
   logic         ready [2];
   logic         valid [2];
   logic [127:0] rdata [2];

   int tests = 0;
   int fails = 0;

   dm_main_memory_responder #(.LATENCY(4)) u_dut0 (
      .clk(clk), .rst(rst), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
      .mem_wdata(wdata[0]), .mem_ready(ready[0]), .mem_resp_valid(valid[0]), .mem_rdata(rdata[0]));

   dm_main_memory_responder #(.LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
      .mem_wdata(wdata[1]), .mem_ready(ready[1]), .mem_resp_valid(valid[1]), .mem_rdata(rdata[1]));

   always #5 clk = ~clk;

   function automatic int lat_of(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   task automatic check(input string nm, input int d, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %h required %h", nm, d, got, exp);
      end
   endtask

   // Model: each request is timestamped by edge number; the response edge is acceptance + LATENCY.
   int           n = 0;
   int           acc       [2] = '{-1, -1};
   int           clr       [2] = '{0, 0};
   logic         p_we      [2];
   logic [11:0]  p_idx     [2];
   logic [127:0] p_wd      [2];
   logic [127:0] exp_rd    [2] = '{128'h0, 128'h0};
   bit           exp_known [2] = '{1'b1, 1'b1};
   logic [127:0] mmem      [2][4096];
   bit           mknown    [2][4096];

   always @(posedge clk) begin
      n = n + 1;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            acc[d] = -1;
            clr[d] = CLR_CYC;
            exp_rd[d] = '0;
            exp_known[d] = 1'b1;
            if (CLR_CYC != 0)
               for (int k = 0; k < 4096; k++) begin
                  mmem[d][k] = '0;
                  mknown[d][k] = 1'b1;
               end
         end else if (clr[d] > 0) begin
            clr[d] = clr[d] - 1;
         end else if (acc[d] >= 0) begin
            if (n == acc[d] + lat_of(d)) begin
               if (p_we[d]) begin
                  mmem[d][p_idx[d]] = p_wd[d];
                  mknown[d][p_idx[d]] = 1'b1;
                  exp_rd[d] = '0;
                  exp_known[d] = 1'b1;
               end else begin
                  exp_rd[d] = mmem[d][p_idx[d]];
                  exp_known[d] = mknown[d][p_idx[d]];
               end
            end else if (n == acc[d] + lat_of(d) + 1) begin
               acc[d] = -1;
            end
         end else if (req[d]) begin
            acc[d] = n;
            p_we[d] = we[d];
            p_idx[d] = addr[d][15:4];
            p_wd[d] = wdata[d];
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         check("ready", d, {127'h0, ready[d]},
               {127'h0, rst ? RST_READY : (clr[d] == 0 && acc[d] < 0)});
         check("resp_valid", d, {127'h0, valid[d]},
               {127'h0, !rst && acc[d] >= 0 && n == acc[d] + lat_of(d)});
         if (exp_known[d]) check("rdata", d, rdata[d], exp_rd[d]);
      end
   end

   task automatic txn(input int d, input logic w, input logic [15:0] a, input logic [127:0] wd,
                      input bit hold, output logic [127:0] rd, output int lat);
      int g;
      @(negedge clk);
      req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
      g = 0;
      while (!ready[d] && g < 10000) begin
         @(negedge clk);
         g++;
      end
      if (!ready[d]) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout dut%0d: ready=%0b required 1", d, ready[d]);
         req[d] = 1'b0;
         rd = 'x;
         lat = -1;
         return;
      end
      @(negedge clk);
      if (hold) begin
         addr[d] = 16'h0040; we[d] = 1'b1; wdata[d] = P3;
      end else begin
         req[d] = 1'b0;
         wdata[d] = {$urandom, $urandom, $urandom, $urandom};
         addr[d] = 16'($urandom);
         we[d] = 1'($urandom);
      end
      lat = 0;
      while (!valid[d] && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      rd = rdata[d];
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] rd;
      int           lat;
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      end
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;

`ifdef MEM_ZERO_INIT_EN
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'hABC0; wdata[0] = '1;
      repeat (100) @(negedge clk);
      req[0] = 1'b0;
      txn(0, 1'b0, 16'hABC0, '0, 1'b0, rd, lat);
      check("t6_rdata", 0, rd, 128'h0);
`endif

      txn(0, 1'b1, 16'h1234, P1, 1'b0, rd, lat);
      check("t1_lat", 0, 128'(lat), 128'd4);
      check("t1_rdata", 0, rd, 128'h0);
      txn(0, 1'b0, 16'h123C, '0, 1'b0, rd, lat);
      check("t2_rdata", 0, rd, P1);

      txn(0, 1'b0, 16'h1230, '0, 1'b1, rd, lat);
      txn(0, 1'b1, 16'h0040, P3, 1'b0, rd, lat);
      check("t3_lat", 0, 128'(lat), 128'd4);
      txn(0, 1'b0, 16'h0048, '0, 1'b0, rd, lat);
      check("t3_rdata", 0, rd, P3);

      txn(0, 1'b1, 16'h8000, P4, 1'b0, rd, lat);
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h8000; wdata[0] = '1;
      @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);
      do_reset();
      @(negedge clk);
      check("t4_ready", 0, {127'h0, ready[0]}, {127'h0, RST_READY});
      txn(0, 1'b0, 16'h8000, '0, 1'b0, rd, lat);
`ifdef MEM_ZERO_INIT_EN
      check("t4_rdata", 0, rd, 128'h0);
`else
      check("t4_rdata", 0, rd, P4);
`endif

      txn(1, 1'b1, 16'h0000, P5A, 1'b0, rd, lat);
      check("t5_lat", 1, 128'(lat), 128'd1);
      txn(1, 1'b1, 16'hFFF0, P5B, 1'b0, rd, lat);
      txn(1, 1'b0, 16'h0004, '0, 1'b0, rd, lat);
      check("t5_rdata_lo", 1, rd, P5A);
      txn(1, 1'b0, 16'hFFFF, '0, 1'b0, rd, lat);
      check("t5_rdata_hi", 1, rd, P5B);
      check("t5_lat_rd", 1, 128'(lat), 128'd1);

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 60; i++) begin
            logic [15:0] a;
            a = {3'($urandom_range(0, 7)), 9'($urandom), 4'($urandom)};
            txn(d, 1'($urandom), a, {$urandom, $urandom, $urandom, $urandom}, 1'b0, rd, lat);
            check("rand_lat", d, 128'(lat), 128'(lat_of(d)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
